trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences exceptions, interrupts and mret through a
// drain / commit / redirect handshake with the pipeline.
// An accepted event raises stall in the same cycle. The FSM then waits in
// DRAIN for pipe_idle, pulses ctrl_trap for one cycle (COMMIT) and
// redirect_valid for one cycle (REDIRECT), and returns to IDLE.
// Optional build macro: TRAP_CTRL_IRQ_SYNC_EN puts a two-flop synchroniser
// on the three interrupt lines, which adds two cycles of interrupt latency.
module trap_ctrl (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset_n,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        mret_req,
  input  logic [31:0] next_pc,
  input  logic        pipe_idle,
  input  logic        irq_msi,
  input  logic        irq_mti,
  input  logic        irq_mei,
  input  logic        csr_mie,
  input  logic        en_msi,
  input  logic        en_mti,
  input  logic        en_mei,
  output logic        stall,
  output logic        ctrl_trap,
  output logic        ctrl_mret,
  output logic [4:0]  trap_info,
  output logic [31:0] trap_pc,
  output logic        redirect_valid,
  output logic        redirect_sel
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  // Interrupt cause codes
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  state_e      state_q;
  logic        stall_q;
  logic        kind_mret_q;
  logic        ctrl_trap_q;
  logic        ctrl_mret_q;
  logic        redirect_valid_q;
  logic        redirect_sel_q;
  logic [4:0]  trap_info_q;
  logic [31:0] trap_pc_q;

  logic [1:0]  rst_sync_q;
  logic        rst_ok;

  logic [2:0]  irq_raw;   // {mei, mti, msi}
  logic [2:0]  irq_line;
  logic [2:0]  irq_pend;

  logic        accept;
  logic        kind_mret_d;
  logic [4:0]  trap_info_d;
  logic [31:0] trap_pc_d;

  // Reset release synchroniser: the assertion of reset is immediate, but
  // event acceptance only resumes two clock edges after release.
  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_ok  = rst_sync_q[1];
  assign irq_raw = {irq_mei, irq_mti, irq_msi};

`ifdef TRAP_CTRL_IRQ_SYNC_EN
  logic [2:0] irq_s1_q;
  logic [2:0] irq_s2_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_irq_sync
    // Two-flop synchroniser per level interrupt line
    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
        irq_s1_q[gi] <= 1'b0;
        irq_s2_q[gi] <= 1'b0;
      end else begin
        irq_s1_q[gi] <= irq_raw[gi];
        irq_s2_q[gi] <= irq_s1_q[gi];
      end
    end
  end

  assign irq_line = irq_s2_q;
`else
  assign irq_line = irq_raw;
`endif

  // An interrupt is pending only with the global enable and its own enable
  assign irq_pend = irq_line & {en_mei, en_mti, en_msi} & {3{csr_mie}};

  // Event arbitration in IDLE: exception > mret > MEI > MSI > MTI
  always_comb begin
    accept      = 1'b0;
    kind_mret_d = 1'b0;
    trap_info_d = trap_info_q;
    trap_pc_d   = trap_pc_q;
    if (state_q == ST_IDLE && rst_ok) begin
      if (exc_valid) begin
        accept      = 1'b1;
        trap_info_d = {1'b0, exc_code};
        trap_pc_d   = exc_pc;
      end else if (mret_req) begin
        accept      = 1'b1;
        kind_mret_d = 1'b1;
        trap_info_d = 5'd0;
      end else if (irq_pend[2]) begin
        accept      = 1'b1;
        trap_info_d = {1'b1, CODE_MEI};
        trap_pc_d   = next_pc;
      end else if (irq_pend[0]) begin
        accept      = 1'b1;
        trap_info_d = {1'b1, CODE_MSI};
        trap_pc_d   = next_pc;
      end else if (irq_pend[1]) begin
        accept      = 1'b1;
        trap_info_d = {1'b1, CODE_MTI};
        trap_pc_d   = next_pc;
      end
    end
  end

  // Main FSM with registered pulse outputs; reset aborts any operation
  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q          <= ST_IDLE;
      stall_q          <= 1'b0;
      kind_mret_q      <= 1'b0;
      ctrl_trap_q      <= 1'b0;
      ctrl_mret_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_sel_q   <= 1'b0;
      trap_info_q      <= 5'd0;
      trap_pc_q        <= 32'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_DRAIN;
            stall_q     <= 1'b1;
            kind_mret_q <= kind_mret_d;
            trap_info_q <= trap_info_d;
            trap_pc_q   <= trap_pc_d;
          end
        end
        ST_DRAIN: begin
          // New events are ignored here; only pipe_idle matters
          if (pipe_idle) begin
            state_q     <= ST_COMMIT;
            ctrl_trap_q <= 1'b1;
            ctrl_mret_q <= kind_mret_q;
          end
        end
        ST_COMMIT: begin
          state_q          <= ST_REDIRECT;
          ctrl_trap_q      <= 1'b0;
          ctrl_mret_q      <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_sel_q   <= kind_mret_q;
        end
        ST_REDIRECT: begin
          state_q          <= ST_IDLE;
          stall_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          redirect_sel_q   <= 1'b0;
        end
        default: begin
          state_q          <= ST_IDLE;
          stall_q          <= 1'b0;
          ctrl_trap_q      <= 1'b0;
          ctrl_mret_q      <= 1'b0;
          redirect_valid_q <= 1'b0;
          redirect_sel_q   <= 1'b0;
        end
      endcase
    end
  end

  // stall covers the accepting IDLE cycle combinationally
  assign stall          = stall_q | accept;
  assign ctrl_trap      = ctrl_trap_q;
  assign ctrl_mret      = ctrl_mret_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_sel   = redirect_sel_q;
  assign trap_info      = trap_info_q;
  assign trap_pc        = trap_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl. Inputs change 1 ns after the rising
// edge and outputs are sampled 2 ns after the rising edge.
module tb_trap_ctrl;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  logic        ctrl_clk;
  logic        ctrl_reset_n;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic        mret_req;
  logic [31:0] next_pc;
  logic        pipe_idle;
  logic        irq_msi, irq_mti, irq_mei;
  logic        csr_mie, en_msi, en_mti, en_mei;
  logic        stall, ctrl_trap, ctrl_mret;
  logic [4:0]  trap_info;
  logic [31:0] trap_pc;
  logic        redirect_valid, redirect_sel;

  logic [4:0]  ctl;
  int          n_checks;
  int          n_fail;

  // {stall, ctrl_trap, ctrl_mret, redirect_valid, redirect_sel}
  assign ctl = {stall, ctrl_trap, ctrl_mret, redirect_valid, redirect_sel};

  trap_ctrl dut (
    .ctrl_clk      (ctrl_clk),
    .ctrl_reset_n  (ctrl_reset_n),
    .exc_valid     (exc_valid),
    .exc_code      (exc_code),
    .exc_pc        (exc_pc),
    .mret_req      (mret_req),
    .next_pc       (next_pc),
    .pipe_idle     (pipe_idle),
    .irq_msi       (irq_msi),
    .irq_mti       (irq_mti),
    .irq_mei       (irq_mei),
    .csr_mie       (csr_mie),
    .en_msi        (en_msi),
    .en_mti        (en_mti),
    .en_mei        (en_mei),
    .stall         (stall),
    .ctrl_trap     (ctrl_trap),
    .ctrl_mret     (ctrl_mret),
    .trap_info     (trap_info),
    .trap_pc       (trap_pc),
    .redirect_valid(redirect_valid),
    .redirect_sel  (redirect_sel)
  );

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    exc_valid = 1'b0; exc_code = 4'd0; exc_pc = 32'd0; mret_req = 1'b0;
    next_pc = 32'd0; pipe_idle = 1'b0;
    irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
    csr_mie = 1'b0; en_msi = 1'b0; en_mti = 1'b0; en_mei = 1'b0;
    #2;
    n_checks++;
    if (ctl !== 5'b00000 || trap_info !== 5'd0 || trap_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl=%b info=%h pc=%h, required ctl=00000 info=00 pc=0", ctl, trap_info, trap_pc);
    end
    step();
    exc_valid = 1'b1; exc_code = 4'd1; exc_pc = 32'h40; pipe_idle = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_no_accept: stall=%b, required 0", stall);
    end
    step();
    ctrl_reset_n = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL release_edge0: stall=%b, required 0", stall);
    end
    step();
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL release_edge1: stall=%b, required 0", stall);
    end
    step();
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL release_edge2_accept: stall=%b, required 1", stall);
    end
    step();
    exc_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b11000 || trap_info !== 5'h01 || trap_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL post_reset_commit: ctl=%b info=%h pc=%h, required ctl=11000 info=01 pc=40", ctl, trap_info, trap_pc);
    end
    step();
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b00000) begin
      n_fail++;
      $display("FAIL post_reset_idle: ctl=%b, required 00000", ctl);
    end
    $display("reset: released, first exception accepted on 2nd edge");
  endtask

  task automatic test_exception();
    exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h100; pipe_idle = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 5'b10000) begin
      n_fail++;
      $display("FAIL exc_accept: ctl=%b, required 10000", ctl);
    end
    step();
    exc_valid = 1'b0; exc_code = 4'd0; exc_pc = 32'd0;
    #1;
    n_checks++;
    if (ctl !== 5'b10000) begin
      n_fail++;
      $display("FAIL exc_drain: ctl=%b, required 10000", ctl);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b11000 || trap_info !== 5'h02 || trap_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL exc_commit: ctl=%b info=%h pc=%h, required ctl=11000 info=02 pc=100", ctl, trap_info, trap_pc);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b10010) begin
      n_fail++;
      $display("FAIL exc_redirect: ctl=%b, required 10010", ctl);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b00000) begin
      n_fail++;
      $display("FAIL exc_idle: ctl=%b, required 00000", ctl);
    end
    $display("exception: code=2 pc=0x100 committed");
  endtask

  task automatic test_irq_priority();
    csr_mie = 1'b1; en_msi = 1'b1; en_mti = 1'b1; en_mei = 1'b1;
    irq_mei = 1'b1; irq_mti = 1'b1; next_pc = 32'h200; pipe_idle = 1'b1;
    for (int k = 0; k <= IRQ_LAT; k++) begin
      #1;
      n_checks++;
      if (stall !== (k == IRQ_LAT)) begin
        n_fail++;
        $display("FAIL irq_latency_k%0d: stall=%b, required %b", k, stall, (k == IRQ_LAT));
      end
      if (k < IRQ_LAT) step();
    end
    step();
    irq_mei = 1'b0; next_pc = 32'h300;
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b11000 || trap_info !== 5'h1B || trap_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL mei_commit: ctl=%b info=%h pc=%h, required ctl=11000 info=1b pc=200", ctl, trap_info, trap_pc);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b10010) begin
      n_fail++;
      $display("FAIL mei_redirect: ctl=%b, required 10010", ctl);
    end
    step();
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_mti_accept: stall=%b, required 1", stall);
    end
    step();
    irq_mti = 1'b0;
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b11000 || trap_info !== 5'h17 || trap_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL mti_commit: ctl=%b info=%h pc=%h, required ctl=11000 info=17 pc=300", ctl, trap_info, trap_pc);
    end
    step();
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b00000) begin
      n_fail++;
      $display("FAIL mti_idle: ctl=%b, required 00000", ctl);
    end
    csr_mie = 1'b0;
    $display("interrupts: MEI then MTI taken back-to-back");
  endtask

  task automatic test_mret_vs_irq();
    csr_mie = 1'b1; irq_mei = 1'b1; mret_req = 1'b1; next_pc = 32'h400; pipe_idle = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mret_accept: stall=%b, required 1", stall);
    end
    step();
    mret_req = 1'b0;
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b11100 || trap_info !== 5'h00 || trap_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL mret_commit: ctl=%b info=%h pc=%h, required ctl=11100 info=00 pc=300", ctl, trap_info, trap_pc);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b10011) begin
      n_fail++;
      $display("FAIL mret_redirect: ctl=%b, required 10011", ctl);
    end
    step();
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_after_mret_accept: stall=%b, required 1", stall);
    end
    step();
    irq_mei = 1'b0;
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b11000 || trap_info !== 5'h1B || trap_pc !== 32'h400) begin
      n_fail++;
      $display("FAIL irq_after_mret_commit: ctl=%b info=%h pc=%h, required ctl=11000 info=1b pc=400", ctl, trap_info, trap_pc);
    end
    step();
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b00000) begin
      n_fail++;
      $display("FAIL mret_seq_idle: ctl=%b, required 00000", ctl);
    end
    csr_mie = 1'b0;
    $display("mret: won over MEI, MEI taken afterwards");
  endtask

  task automatic test_drain_hold();
    exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h500; pipe_idle = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_accept: stall=%b, required 1", stall);
    end
    step();
    for (int c = 1; c <= 6; c++) begin
      exc_valid = (c == 3);
      exc_code  = 4'd9;
      exc_pc    = 32'h900;
      mret_req  = (c == 4);
      pipe_idle = (c == 6);
      #1;
      n_checks++;
      if (ctl !== 5'b10000) begin
        n_fail++;
        $display("FAIL hold_drain_c%0d: ctl=%b, required 10000", c, ctl);
      end
      step();
    end
    exc_valid = 1'b0; mret_req = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 5'b11000 || trap_info !== 5'h05 || trap_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL hold_commit_c7: ctl=%b info=%h pc=%h, required ctl=11000 info=05 pc=500", ctl, trap_info, trap_pc);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b10010) begin
      n_fail++;
      $display("FAIL hold_redirect: ctl=%b, required 10010", ctl);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b00000) begin
      n_fail++;
      $display("FAIL hold_idle: ctl=%b, required 00000", ctl);
    end
    $display("drain hold: 5 busy cycles, trap on cycle +7 with original cause");
  endtask

  task automatic test_reset_mid();
    exc_valid = 1'b1; exc_code = 4'd6; exc_pc = 32'h600; pipe_idle = 1'b0;
    #1;
    step();
    exc_valid = 1'b0;
    ctrl_reset_n = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 5'b00000 || trap_info !== 5'd0 || trap_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: ctl=%b info=%h pc=%h, required ctl=00000 info=00 pc=0", ctl, trap_info, trap_pc);
    end
    pipe_idle = 1'b1;
    step();
    step();
    ctrl_reset_n = 1'b1;
    irq_msi = 1'b1; en_msi = 1'b1; csr_mie = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (ctl !== 5'b00000) begin
        n_fail++;
        $display("FAIL masked_msi_c%0d: ctl=%b, required 00000", c, ctl);
      end
      step();
    end
    irq_msi = 1'b0;
    step(); step(); step();
    csr_mie = 1'b1; irq_msi = 1'b1; next_pc = 32'h700;
    for (int k = 0; k <= IRQ_LAT; k++) begin
      #1;
      n_checks++;
      if (stall !== (k == IRQ_LAT)) begin
        n_fail++;
        $display("FAIL msi_latency_k%0d: stall=%b, required %b", k, stall, (k == IRQ_LAT));
      end
      if (k < IRQ_LAT) step();
    end
    step();
    irq_msi = 1'b0; csr_mie = 1'b0;
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b11000 || trap_info !== 5'h13 || trap_pc !== 32'h700) begin
      n_fail++;
      $display("FAIL msi_commit: ctl=%b info=%h pc=%h, required ctl=11000 info=13 pc=700", ctl, trap_info, trap_pc);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b10010) begin
      n_fail++;
      $display("FAIL msi_redirect: ctl=%b, required 10010", ctl);
    end
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b00000) begin
      n_fail++;
      $display("FAIL msi_idle: ctl=%b, required 00000", ctl);
    end
    $display("mid-drain reset: aborted, masked MSI held off, MSI taken once enabled");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_exception();
    test_irq_priority();
    test_mret_vs_irq();
    test_drain_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
